cpu_control_fsm: RTL and testbench

Instruction sequencer for the PIC10-compatible CPU core. It decodes the 12-bit baseline instruction held in the instruction register and drives every strobe and mux select of the core datapath. Those datapath signals cover the ALU/W register, STATUS, PC/stack, FSR/RAM and the three GPIO/TRIS ports, over a fixed three-state FETCH/EXEC/WRITE cycle. It sits beside the datapath inside the CPU core; the two together form the complete core.

---
 rtl/cpu_control_fsm.sv | 176 +++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_fsm
// Brief    : FETCH/EXEC/WRITE sequencer and strobe decoder for the PIC10 core
// Revision : 1.0 - initial release
// ============================================================================
module cpu_control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] instruction_reg_out,
    input  logic [4:0]  reg_address,
    input  logic        zero_result,
    output logic        store_alu_w,
    output logic        alu_in_select,
    output logic        load_status_reg,
    output logic        skip_next_instruction,
    output logic        load_instruction_reg,
    output logic [1:0]  pc_mux_select,
    output logic        load_pc,
    output logic        inc_pc,
    output logic        inc_stack,
    output logic        dec_stack,
    output logic        load_stack,
    output logic        load_fsr,
    output logic        reg_address_mux_select,
    output logic        load_ram,
    output logic        load_tris0,
    output logic        load_tris1,
    output logic        load_tris2,
    output logic        load_gpio0,
    output logic        load_gpio1,
    output logic        load_gpio2,
    output logic        halted
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_SLEEP = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_skip_pending;

    logic [5:0] w_op6;
    logic       w_d;
    logic       w_movwf, w_clrw, w_clrf, w_byte_op, w_byte_status;
    logic       w_decfsz, w_incfsz, w_bit_op, w_bcf_bsf, w_btfsc, w_btfss;
    logic       w_retlw, w_call, w_goto, w_lit_alu, w_lit_logic;
    logic       w_sleep, w_tris, w_file_op, w_reg_dest, w_indf, w_skip_cond;

    assign w_op6         = instruction_reg_out[11:6];
    assign w_d           = instruction_reg_out[5];
    assign w_movwf       = (instruction_reg_out[11:5] == 7'b0000001);
    assign w_clrw        = (instruction_reg_out[11:5] == 7'b0000010);
    assign w_clrf        = (instruction_reg_out[11:5] == 7'b0000011);
    assign w_byte_op     = (instruction_reg_out[11:10] == 2'b00) && (instruction_reg_out[9:7] != 3'b000);
    assign w_decfsz      = (w_op6 == 6'b001011);
    assign w_incfsz      = (w_op6 == 6'b001111);
    // Byte ops that leave STATUS alone: DECFSZ, SWAPF, INCFSZ
    assign w_byte_status = w_byte_op && !w_decfsz && !w_incfsz && (w_op6 != 6'b001110);
    assign w_bit_op      = (instruction_reg_out[11:10] == 2'b01);
    assign w_bcf_bsf     = (instruction_reg_out[11:9] == 3'b010);
    assign w_btfsc       = (instruction_reg_out[11:8] == 4'b0110);
    assign w_btfss       = (instruction_reg_out[11:8] == 4'b0111);
    assign w_retlw       = (instruction_reg_out[11:8] == 4'b1000);
    assign w_call        = (instruction_reg_out[11:8] == 4'b1001);
    assign w_goto        = (instruction_reg_out[11:9] == 3'b101);
    assign w_lit_alu     = (instruction_reg_out[11:10] == 2'b11);
    assign w_lit_logic   = w_lit_alu && (instruction_reg_out[9:8] != 2'b00);
    assign w_sleep       = (instruction_reg_out == 12'h003);
    assign w_tris        = (instruction_reg_out[11:3] == 9'd0) && (instruction_reg_out[2:0] >= 3'd5);
    assign w_file_op     = w_movwf || w_clrf || w_byte_op || w_bit_op;
    assign w_reg_dest    = w_movwf || w_clrf || (w_byte_op && w_d) || w_bcf_bsf;
    assign w_indf        = w_file_op && (instruction_reg_out[4:0] == 5'd0);

    // A PCL destination redirects the next fetch, so it must not arm a skip
    assign w_skip_cond = ((w_decfsz || w_incfsz) && zero_result && !(w_d && reg_address == 5'd2))
                       || (w_btfsc && zero_result)
                       || (w_btfss && !zero_result);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_WRITE;
            S_WRITE: w_state_next = w_sleep ? S_SLEEP : S_FETCH;
            default: w_state_next = S_SLEEP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_FETCH;
            r_skip_pending <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_FETCH)
                r_skip_pending <= 1'b0;
            else if (r_state == S_WRITE)
                r_skip_pending <= w_skip_cond;
        end
    end

    // Outputs are forced low while reset is held, independent of state
    always_comb begin
        store_alu_w            = 1'b0;
        alu_in_select          = 1'b0;
        load_status_reg        = 1'b0;
        skip_next_instruction  = 1'b0;
        load_instruction_reg   = 1'b0;
        pc_mux_select          = 2'b00;
        load_pc                = 1'b0;
        inc_pc                 = 1'b0;
        inc_stack              = 1'b0;
        dec_stack              = 1'b0;
        load_stack             = 1'b0;
        load_fsr               = 1'b0;
        reg_address_mux_select = 1'b0;
        load_ram               = 1'b0;
        load_tris0             = 1'b0;
        load_tris1             = 1'b0;
        load_tris2             = 1'b0;
        load_gpio0             = 1'b0;
        load_gpio1             = 1'b0;
        load_gpio2             = 1'b0;
        halted                 = 1'b0;
        if (rst) begin
            case (r_state)
                S_FETCH: begin
                    load_instruction_reg  = 1'b1;
                    inc_pc                = 1'b1;
                    skip_next_instruction = r_skip_pending;
                end
                S_EXEC: begin
                    reg_address_mux_select = w_indf;
                    alu_in_select          = w_lit_alu || w_retlw;
                    store_alu_w            = (w_byte_op && !w_d) || w_clrw || w_lit_alu || w_retlw;
                    load_status_reg        = w_byte_status || w_clrf || w_clrw || w_lit_logic;
                    inc_stack              = w_call;
                end
                S_WRITE: begin
                    reg_address_mux_select = w_indf;
                    if (w_reg_dest) begin
                        if (reg_address == 5'd2) begin
                            load_pc       = 1'b1;
                            pc_mux_select = 2'b01;
                        end
                        load_status_reg = (reg_address == 5'd3);
                        load_fsr        = (reg_address == 5'd4);
                        load_gpio0      = (reg_address == 5'd5);
                        load_gpio1      = (reg_address == 5'd6);
                        load_gpio2      = (reg_address == 5'd7);
                        load_ram        = (reg_address >= 5'd8);
                    end else if (w_goto) begin
                        load_pc = 1'b1;
                    end else if (w_call) begin
                        load_pc    = 1'b1;
                        load_stack = 1'b1;
                    end else if (w_retlw) begin
                        load_pc       = 1'b1;
                        pc_mux_select = 2'b10;
                        dec_stack     = 1'b1;
                    end else if (w_tris) begin
                        load_tris0 = (instruction_reg_out[2:0] == 3'd5);
                        load_tris1 = (instruction_reg_out[2:0] == 3'd6);
                        load_tris2 = (instruction_reg_out[2:0] == 3'd7);
                    end
                end
                default: halted = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_control_fsm
// Brief    : Directed vector bench for the CPU control sequencer
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] instr = 12'h000;
    logic [4:0]  addr = 5'd0;
    logic        zero = 1'b0;
    logic        store_alu_w, alu_in_select, load_status_reg, skip_next_instruction;
    logic        load_instruction_reg, load_pc, inc_pc, inc_stack, dec_stack, load_stack;
    logic        load_fsr, reg_address_mux_select, load_ram;
    logic        load_tris0, load_tris1, load_tris2, load_gpio0, load_gpio1, load_gpio2, halted;
    logic [1:0]  pc_mux_select;
    logic [21:0] obs;

    int checks = 0;
    int errors = 0;

    localparam logic [21:0] SW   = 22'd1 << 21;
    localparam logic [21:0] AIS  = 22'd1 << 20;
    localparam logic [21:0] ST   = 22'd1 << 19;
    localparam logic [21:0] SKIP = 22'd1 << 18;
    localparam logic [21:0] LIR  = 22'd1 << 17;
    localparam logic [21:0] MSTK = 22'd2 << 15;
    localparam logic [21:0] MALU = 22'd1 << 15;
    localparam logic [21:0] LPC  = 22'd1 << 14;
    localparam logic [21:0] IPC  = 22'd1 << 13;
    localparam logic [21:0] ISTK = 22'd1 << 12;
    localparam logic [21:0] DSTK = 22'd1 << 11;
    localparam logic [21:0] LSTK = 22'd1 << 10;
    localparam logic [21:0] FSR  = 22'd1 << 9;
    localparam logic [21:0] MUX  = 22'd1 << 8;
    localparam logic [21:0] RAM  = 22'd1 << 7;
    localparam logic [21:0] TR0  = 22'd1 << 6;
    localparam logic [21:0] TR1  = 22'd1 << 5;
    localparam logic [21:0] TR2  = 22'd1 << 4;
    localparam logic [21:0] GP0  = 22'd1 << 3;
    localparam logic [21:0] GP1  = 22'd1 << 2;
    localparam logic [21:0] GP2  = 22'd1 << 1;
    localparam logic [21:0] HALT = 22'd1;
    localparam logic [21:0] FETCH_EXP = LIR | IPC;

    cpu_control_fsm dut (
        .clk                    (clk),
        .rst                    (rst),
        .instruction_reg_out    (instr),
        .reg_address            (addr),
        .zero_result            (zero),
        .store_alu_w            (store_alu_w),
        .alu_in_select          (alu_in_select),
        .load_status_reg        (load_status_reg),
        .skip_next_instruction  (skip_next_instruction),
        .load_instruction_reg   (load_instruction_reg),
        .pc_mux_select          (pc_mux_select),
        .load_pc                (load_pc),
        .inc_pc                 (inc_pc),
        .inc_stack              (inc_stack),
        .dec_stack              (dec_stack),
        .load_stack             (load_stack),
        .load_fsr               (load_fsr),
        .reg_address_mux_select (reg_address_mux_select),
        .load_ram               (load_ram),
        .load_tris0             (load_tris0),
        .load_tris1             (load_tris1),
        .load_tris2             (load_tris2),
        .load_gpio0             (load_gpio0),
        .load_gpio1             (load_gpio1),
        .load_gpio2             (load_gpio2),
        .halted                 (halted)
    );

    assign obs = {store_alu_w, alu_in_select, load_status_reg, skip_next_instruction,
                  load_instruction_reg, pc_mux_select, load_pc, inc_pc, inc_stack,
                  dec_stack, load_stack, load_fsr, reg_address_mux_select, load_ram,
                  load_tris0, load_tris1, load_tris2, load_gpio0, load_gpio1,
                  load_gpio2, halted};

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] instr;
        logic [4:0]  addr;
        logic        zero;
        logic [21:0] exec_exp;
        logic [21:0] write_exp;
        logic        skip;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [11:0] i, logic [4:0] a, logic z,
                                logic [21:0] e, logic [21:0] w, logic s);
        vec_t v;
        v.instr = i; v.addr = a; v.zero = z;
        v.exec_exp = e; v.write_exp = w; v.skip = s;
        return v;
    endfunction

    task automatic check(string name, logic [21:0] act, logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h", name, act, exp);
        end
    endtask

    // Entered at a negedge while the DUT is in S_FETCH; leaves at the next S_FETCH negedge
    task automatic run_vec(int idx, logic skip_in);
        instr = vecs[idx].instr;
        addr  = vecs[idx].addr;
        zero  = vecs[idx].zero;
        #1 check($sformatf("v%0d_fetch(%03h)", idx, vecs[idx].instr), obs,
                 FETCH_EXP | (skip_in ? SKIP : 22'd0));
        @(negedge clk);
        check($sformatf("v%0d_exec(%03h)", idx, vecs[idx].instr), obs, vecs[idx].exec_exp);
        @(negedge clk);
        check($sformatf("v%0d_write(%03h)", idx, vecs[idx].instr), obs, vecs[idx].write_exp);
        @(negedge clk);
    endtask

    initial begin
        logic sk;
        vecs.push_back(mk(12'hC55, 5'h15, 1'b0, SW | AIS, 22'd0, 1'b0));        // MOVLW 0x55
        vecs.push_back(mk(12'h1F0, 5'h10, 1'b0, ST, RAM, 1'b0));                // ADDWF 0x10,1
        vecs.push_back(mk(12'h026, 5'h06, 1'b0, 22'd0, GP1, 1'b0));             // MOVWF 0x06
        vecs.push_back(mk(12'h2EA, 5'h0A, 1'b1, 22'd0, RAM, 1'b1));             // DECFSZ z=1
        vecs.push_back(mk(12'h000, 5'h00, 1'b0, 22'd0, 22'd0, 1'b0));           // NOP (skipped)
        vecs.push_back(mk(12'h2EA, 5'h0A, 1'b0, 22'd0, RAM, 1'b0));             // DECFSZ z=0
        vecs.push_back(mk(12'h765, 5'h05, 1'b0, 22'd0, 22'd0, 1'b1));           // BTFSS z=0
        vecs.push_back(mk(12'h000, 5'h00, 1'b0, 22'd0, 22'd0, 1'b0));           // NOP
        vecs.push_back(mk(12'h920, 5'h00, 1'b0, ISTK, LSTK | LPC, 1'b0));       // CALL 0x20
        vecs.push_back(mk(12'h807, 5'h00, 1'b0, SW | AIS, LPC | MSTK | DSTK, 1'b0)); // RETLW
        vecs.push_back(mk(12'h006, 5'h00, 1'b0, 22'd0, TR1, 1'b0));             // TRIS 6
        vecs.push_back(mk(12'h005, 5'h00, 1'b0, 22'd0, TR0, 1'b0));             // TRIS 5
        vecs.push_back(mk(12'h007, 5'h00, 1'b0, 22'd0, TR2, 1'b0));             // TRIS 7
        vecs.push_back(mk(12'h020, 5'h00, 1'b0, MUX, MUX, 1'b0));               // MOVWF INDF -> 0
        vecs.push_back(mk(12'h020, 5'h12, 1'b0, MUX, MUX | RAM, 1'b0));         // MOVWF INDF -> 0x12
        vecs.push_back(mk(12'h022, 5'h02, 1'b0, 22'd0, LPC | MALU, 1'b0));      // MOVWF PCL
        vecs.push_back(mk(12'h023, 5'h03, 1'b0, 22'd0, ST, 1'b0));              // MOVWF STATUS
        vecs.push_back(mk(12'h024, 5'h04, 1'b0, 22'd0, FSR, 1'b0));             // MOVWF FSR
        vecs.push_back(mk(12'h021, 5'h01, 1'b0, 22'd0, 22'd0, 1'b0));           // MOVWF TMR0
        vecs.push_back(mk(12'h025, 5'h05, 1'b0, 22'd0, GP0, 1'b0));             // MOVWF GPIO0
        vecs.push_back(mk(12'h040, 5'h00, 1'b0, SW | ST, 22'd0, 1'b0));         // CLRW
        vecs.push_back(mk(12'h07F, 5'h1F, 1'b0, ST, RAM, 1'b0));                // CLRF 0x1F
        vecs.push_back(mk(12'h390, 5'h10, 1'b0, SW, 22'd0, 1'b0));              // SWAPF 0x10,0
        vecs.push_back(mk(12'h527, 5'h07, 1'b0, 22'd0, GP2, 1'b0));             // BSF 0x07,1
        vecs.push_back(mk(12'hBFF, 5'h00, 1'b0, 22'd0, LPC, 1'b0));             // GOTO 0x1FF
        vecs.push_back(mk(12'h610, 5'h10, 1'b1, 22'd0, 22'd0, 1'b1));           // BTFSC z=1
        vecs.push_back(mk(12'h000, 5'h00, 1'b0, 22'd0, 22'd0, 1'b0));           // NOP
        vecs.push_back(mk(12'h3E2, 5'h02, 1'b1, 22'd0, LPC | MALU, 1'b0));      // INCFSZ PCL,1
        vecs.push_back(mk(12'h3D0, 5'h10, 1'b1, SW, 22'd0, 1'b1));              // INCFSZ 0x10,0
        vecs.push_back(mk(12'h002, 5'h00, 1'b0, 22'd0, 22'd0, 1'b0));           // OPTION (skipped)
        vecs.push_back(mk(12'hF0F, 5'h00, 1'b0, SW | AIS | ST, 22'd0, 1'b0));   // XORLW 0x0F
        vecs.push_back(mk(12'h765, 5'h05, 1'b1, 22'd0, 22'd0, 1'b0));           // BTFSS z=1

        // Reset held from time zero
        repeat (2) @(negedge clk);
        #1 check("reset_hold", obs, 22'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("reset_release_fetch", obs, FETCH_EXP);

        // Reset asserted mid-EXEC of ADDWF 0x10,1
        instr = 12'h1F0; addr = 5'h10; zero = 1'b0;
        @(posedge clk); #2;
        check("abort_exec", obs, ST);
        rst = 1'b0;
        #1 check("abort_async_zero", obs, 22'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("abort_held_%0d", c), obs, 22'd0);
        end
        rst = 1'b1;
        #1 check("abort_release_fetch", obs, FETCH_EXP);

        sk = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, sk);
            sk = vecs[i].skip;
        end

        // Pending skip is discarded by reset
        run_vec(3, sk);
        #1 check("skip_armed", obs, FETCH_EXP | SKIP);
        rst = 1'b0;
        #1 check("skip_reset_zero", obs, 22'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("skip_cleared", obs, FETCH_EXP);

        // SLEEP is absorbing until reset
        vecs.push_back(mk(12'h003, 5'h00, 1'b0, 22'd0, 22'd0, 1'b0));
        run_vec(vecs.size() - 1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1 check($sformatf("sleep_%0d", c), obs, HALT);
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1 check("sleep_reset_zero", obs, 22'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("sleep_wake_fetch", obs, FETCH_EXP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
